// File: rtl/bcrypt_ctrl.sv
// Phase sequencer for the bcrypt datapath: word RX, EksBlowfishSetup expands,
// the ctext encryption loop and word TX. Only the FSM and its counters live here.
module bcrypt_ctrl #(
    parameter int P_BLOCKS = 9,
    parameter int S_BLOCKS = 512,
    parameter int ROUNDS   = 18,
    parameter int CT_ITERS = 64
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic                    cost_is_zero,
    output logic                    shift_key,
    output logic                    shift_salt_r,
    output logic                    shift_salt_l,
    output logic                    sel_salt_r,
    output logic                    sel_salt_l,
    output logic                    sel_salt,
    output logic                    shift_cost,
    output logic                    dec_cost,
    output logic                    sel_p_key,
    output logic [2*P_BLOCKS-1:0]   p_sel,
    output logic                    shift_feistel,
    output logic                    load_feistel_ctext,
    output logic                    feistel_clr,
    output logic                    sel_feistel_salt,
    output logic                    sel_feistel_mem,
    output logic                    shift_ctext_l,
    output logic                    shift_ctext_r,
    output logic                    sel_ct,
    output logic [3:0]              mem_wr_en,
    output logic                    sel_mem_addr,
    output logic                    incr_addr,
    output logic                    incr_sram,
    output logic                    clear_sram_ctrs,
    output logic                    busy,
    output logic                    done
);

    localparam logic [9:0] P_BLK     = 10'(P_BLOCKS);
    localparam logic [9:0] LAST_BLK  = 10'(P_BLOCKS + S_BLOCKS - 1);
    localparam logic [9:0] LAST_CTB  = 10'd2;
    localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);
    localparam logic [4:0] MEM_RNDS  = 5'(ROUNDS - 2);
    localparam logic [6:0] LAST_ITER = 7'(CT_ITERS - 1);
    localparam logic [4:0] LAST_KEY  = 5'd17;
    localparam logic [4:0] LAST_SALT = 5'd3;
    localparam logic [4:0] LAST_TX   = 5'd5;

    localparam logic [1:0] PS_SHIFT = 2'd1;
    localparam logic [1:0] PS_XOR   = 2'd2;
    localparam logic [1:0] PS_LOAD  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, RX_KEY, RX_SALT, RX_COST, XOR_P, MIX, ENC, STORE,
        CHECK, CT_LOAD, CT_STORE, TX, DONE
    } state_t;

    // M_CTEXT marks the ctext loop so ENC knows which store state follows it.
    typedef enum logic [1:0] {M_SALTED, M_KEY, M_SALT, M_CTEXT} mode_t;

    state_t     state, state_n;
    mode_t      mode, mode_n;
    logic [9:0] blk, blk_n;
    logic [4:0] rnd, rnd_n;
    logic [4:0] word, word_n;
    logic [6:0] iter, iter_n;
    logic [8:0] s_idx;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            mode  <= M_SALTED;
            blk   <= '0;
            rnd   <= '0;
            word  <= '0;
            iter  <= '0;
        end else begin
            state <= state_n;
            mode  <= mode_n;
            blk   <= blk_n;
            rnd   <= rnd_n;
            word  <= word_n;
            iter  <= iter_n;
        end
    end

    always_comb begin
        state_n            = state;
        mode_n             = mode;
        blk_n              = blk;
        rnd_n              = rnd;
        word_n             = word;
        iter_n             = iter;
        s_idx              = 9'(blk - P_BLK);
        rx_ready           = 1'b0;
        tx_valid           = 1'b0;
        shift_key          = 1'b0;
        shift_salt_r       = 1'b0;
        shift_salt_l       = 1'b0;
        sel_salt_r         = 1'b0;
        sel_salt_l         = 1'b0;
        sel_salt           = 1'b0;
        shift_cost         = 1'b0;
        dec_cost           = 1'b0;
        sel_p_key          = 1'b0;
        p_sel              = '0;
        shift_feistel      = 1'b0;
        load_feistel_ctext = 1'b0;
        feistel_clr        = 1'b0;
        sel_feistel_salt   = 1'b0;
        sel_feistel_mem    = 1'b0;
        shift_ctext_l      = 1'b0;
        shift_ctext_r      = 1'b0;
        sel_ct             = 1'b0;
        mem_wr_en          = 4'b0000;
        sel_mem_addr       = 1'b0;
        incr_addr          = 1'b0;
        incr_sram          = 1'b0;
        clear_sram_ctrs    = 1'b0;
        busy               = (state != IDLE);
        done               = 1'b0;

        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    shift_key = 1'b1;
                    word_n    = 5'd1;
                    state_n   = RX_KEY;
                end
            end
            RX_KEY: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    shift_key = 1'b1;
                    if (word == LAST_KEY) begin
                        word_n  = '0;
                        state_n = RX_SALT;
                    end else begin
                        word_n = word + 5'd1;
                    end
                end
            end
            RX_SALT: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    shift_salt_r = ~word[0];
                    shift_salt_l = word[0];
                    if (word == LAST_SALT) begin
                        word_n  = '0;
                        state_n = RX_COST;
                    end else begin
                        word_n = word + 5'd1;
                    end
                end
            end
            RX_COST: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    shift_cost = 1'b1;
                    mode_n     = M_SALTED;
                    state_n    = XOR_P;
                end
            end
            XOR_P: begin
                p_sel           = {P_BLOCKS{PS_XOR}};
                sel_p_key       = (mode == M_SALT);
                clear_sram_ctrs = 1'b1;
                feistel_clr     = 1'b1;
                blk_n           = '0;
                rnd_n           = '0;
                state_n         = (mode == M_SALTED) ? MIX : ENC;
            end
            MIX: begin
                // Even blocks take the left salt half, odd the right; the salt rotates as it is used.
                sel_feistel_salt = 1'b1;
                sel_salt         = blk[0];
                shift_salt_r     = blk[0];
                shift_salt_l     = ~blk[0];
                sel_salt_r       = 1'b1;
                sel_salt_l       = 1'b1;
                state_n          = ENC;
            end
            ENC: begin
                shift_feistel   = 1'b1;
                p_sel           = {P_BLOCKS{PS_SHIFT}};
                sel_feistel_mem = (rnd < MEM_RNDS);
                if (rnd == LAST_RND) begin
                    rnd_n   = '0;
                    state_n = (mode == M_CTEXT) ? CT_STORE : STORE;
                end else begin
                    rnd_n = rnd + 5'd1;
                end
            end
            STORE: begin
                if (blk < P_BLK) begin
                    for (int k = 0; k < P_BLOCKS; k++)
                        if (blk == 10'(k)) p_sel[2*k +: 2] = PS_LOAD;
                end else begin
                    sel_mem_addr = 1'b1;
                    mem_wr_en    = 4'b0001 << s_idx[8:7];
                    incr_addr    = 1'b1;
                    incr_sram    = (s_idx[6:0] == 7'h7f);
                end
                if (blk == LAST_BLK) begin
                    blk_n   = '0;
                    state_n = CHECK;
                end else begin
                    blk_n   = blk + 10'd1;
                    state_n = (mode == M_SALTED) ? MIX : ENC;
                end
            end
            CHECK: begin
                if (mode == M_KEY) begin
                    mode_n  = M_SALT;
                    state_n = XOR_P;
                end else if (cost_is_zero) begin
                    mode_n  = M_CTEXT;
                    blk_n   = '0;
                    iter_n  = '0;
                    state_n = CT_LOAD;
                end else begin
                    dec_cost = 1'b1;
                    mode_n   = M_KEY;
                    state_n  = XOR_P;
                end
            end
            CT_LOAD: begin
                load_feistel_ctext = 1'b1;
                rnd_n              = '0;
                state_n            = ENC;
            end
            CT_STORE: begin
                shift_ctext_l = 1'b1;
                shift_ctext_r = 1'b1;
                state_n       = CT_LOAD;
                if (blk == LAST_CTB) begin
                    blk_n = '0;
                    if (iter == LAST_ITER) begin
                        iter_n  = '0;
                        word_n  = '0;
                        state_n = TX;
                    end else begin
                        iter_n = iter + 7'd1;
                    end
                end else begin
                    blk_n = blk + 10'd1;
                end
            end
            TX: begin
                tx_valid = 1'b1;
                sel_ct   = word[0];
                if (tx_ready) begin
                    shift_ctext_l = ~word[0];
                    shift_ctext_r = word[0];
                    if (word == LAST_TX) begin
                        word_n  = '0;
                        state_n = DONE;
                    end else begin
                        word_n = word + 5'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                mode_n  = M_SALTED;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/bcrypt_ctrl.md
# bcrypt_ctrl

Sequencing controller for the bcrypt datapath. Accepts key, salt and cost as 32-bit words from the UART word interface and drives every strobe and select of the datapath. It runs EksBlowfishSetup: one salted expand, then `cost` pairs of key/salt expands. It then encrypts the ctext 64 times and returns 6 ctext words over UART. It holds no key or cipher state itself, only the phase FSM and the block, round and iteration counters.

## Interface
- P_BLOCKS, 9: Feistel blocks written into P pairs per expand.
- S_BLOCKS, 512: blocks written into S-box SRAMs per expand (4 SRAMs × 128 words).
- ROUNDS, 18: shiftFeistel cycles per block encryption.
- CT_ITERS, 64: ctext encryption iterations.
- clk  in  1  clock, all state on posedge.
- reset_l  in  1  asynchronous, active-low reset.
- rx_valid / rx_ready  in / out  1  UART word in; a word is accepted when both are high.
- tx_valid / tx_ready  out / in  1  UART word out; a word is sent when both are high.
- cost_is_zero  in  1  from the datapath cost register.
- shift_key, shift_salt_r, shift_salt_l, sel_salt_r, sel_salt_l, sel_salt, shift_cost, dec_cost  out  1 each  key, salt and cost register controls.
- sel_p_key  out  1  selects the XOR source: 0 = key, 1 = salt.
- p_sel  out  18  2 bits per P pair, pair k at [2k+1:2k]; 0 HOLD, 1 SHIFT, 2 XOR, 3 LOAD.
- shift_feistel, load_feistel_ctext, feistel_clr, sel_feistel_salt, sel_feistel_mem  out  1 each  Feistel controls.
- shift_ctext_l, shift_ctext_r, sel_ct  out  1 each  ctext register controls.
- mem_wr_en  out  4  one-hot SRAM write enable.
- sel_mem_addr  out  1  selects the SRAM address source: 1 = write counter, 0 = Feistel.
- incr_addr, incr_sram, clear_sram_ctrs  out  1 each  SRAM write counter controls.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last tx word.

## Operation
- All outputs are Moore/Mealy strobes. Every output is 0 in reset and in IDLE, except rx_ready = 1 in IDLE, RX_KEY, RX_SALT and RX_COST.
- RX phases:
  - IDLE→RX_KEY on the first accepted word, which counts as key word 0.
  - RX_KEY takes 18 words, shift_key on each accept.
  - RX_SALT takes 4 words, alternating shift_salt_r (words 0 and 2) and shift_salt_l (words 1 and 3), with sel_salt_r = sel_salt_l = 0.
  - RX_COST takes 1 word with shift_cost, then → XOR_P with mode = 0.
- Expand, modes 0/1/2 = salted key / key / salt:
  - XOR_P (1 cycle): every p_sel pair = XOR, sel_p_key = (mode == 2), clear_sram_ctrs = 1, feistel_clr = 1, blk = 0.
  - MIX (mode 0 only, 1 cycle per block): sel_feistel_salt = 1, sel_salt = blk[0], shift_salt_r = blk[0], shift_salt_l = ~blk[0], sel_salt_r = sel_salt_l = 1 (rotate).
  - ENC (ROUNDS cycles, rnd 0..17): shift_feistel = 1 and every p_sel pair = SHIFT, so P rotates back to its original order. sel_feistel_mem = (rnd < 16).
  - STORE (1 cycle), blk < 9: p_sel pair blk = LOAD.
  - STORE, blk ≥ 9: sel_mem_addr = 1, mem_wr_en = 1 << ((blk-9) >> 7), incr_addr = 1, incr_sram = ((blk-9)[6:0] == 127).
  - After STORE: blk++. If blk < 520, go to MIX (mode 0) or ENC; otherwise go to CHECK.
- Expand cycle counts: mode 0 = 1 + 521×20 = 10421 cycles; modes 1 and 2 = 1 + 521×19 = 9900 cycles.
- CHECK (1 cycle), decides the next expand:
  - After mode 0 or mode 2: if cost_is_zero → CT_LOAD, else dec_cost = 1 and → XOR_P with mode 1.
  - After mode 1 → XOR_P with mode 2.
- Ctext loop:
  - CT_LOAD asserts load_feistel_ctext.
  - ENC runs with the same strobes as an expand ENC.
  - CT_STORE asserts shift_ctext_l and shift_ctext_r.
  - 3 blocks per iteration, CT_ITERS iterations: 3840 cycles total, then → TX.
- TX:
  - tx_valid = 1 for 6 words; sel_ct = word index [0].
  - On each send: shift_ctext_l when sel_ct = 0, shift_ctext_r when sel_ct = 1.
  - After word 5: done pulse, → IDLE.
- Counter widths: blk 10 bits, rnd 5 bits, word 5 bits, iter 7 bits. No counter wraps within a phase.

## Timing
- RX strobes are combinational on rx_valid & rx_ready in the accept cycle. The datapath captures the word at the same posedge.
- rx_ready and tx_valid are never high outside their phases. An rx_valid during a busy non-RX phase is ignored.
- The tx word is held stable while tx_valid is high and tx_ready is low.
- Back-pressure stalls the FSM only in RX and TX. All other phases run at fixed cycle counts.
- reset_l low at any point takes the FSM to IDLE and zeros all counters and strobes asynchronously. There is no partial-job resume.

## Test plan
- Reset mid-ENC (rnd = 7) → next cycle all outputs 0, busy = 0, rx_ready = 1.
- Feed 23 words back-to-back → 18 shift_key, then shift_salt_r/l in order R,L,R,L, then 1 shift_cost; XOR_P follows on the next cycle.
- Cost = 0 → exactly one expand (10421 cycles), CHECK, then CT_LOAD. No dec_cost pulse.
- Cost = 2 → expand order 0,1,2,1,2; exactly 2 dec_cost pulses.
- Check store routing across a full expand:
  - p_sel LOAD hits pairs 0..8 in order.
  - mem_wr_en goes 0001 for 128 stores, then 0010, 0100, 1000; incr_sram on stores 127, 255, 383, 511.
- TX with tx_ready toggling every other cycle → 6 sends, sel_ct = 0,1,0,1,0,1, done pulses once, then IDLE.
